// File: rtl/count_down.sv
// count_down: two-digit BCD seconds countdown timer (00..59).
// A prescaler divides clk down to a one-second tick while running.
// The preset is loaded with clamping, and start/pause control the run.
// On expiry the block raises a one-cycle done pulse and holds expired.
module count_down #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_hs,
  input  logic [3:0] ld_ls,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] HS,
  output logic [3:0] LS,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [25:0] PRE_MAX = 26'(TICK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [25:0] r_pre;
  logic [25:0] w_pre_nxt;
  logic [3:0]  w_hs_nxt;
  logic [3:0]  w_ls_nxt;
  logic        w_done_nxt;
  logic        w_tick;
  logic        w_expiring;
  logic [3:0]  w_ld_hs;
  logic [3:0]  w_ld_ls;

  // Preset digits are clamped so the display can never show an illegal time.
  assign w_ld_hs = (ld_hs > 4'd5) ? 4'd5 : ld_hs;
  assign w_ld_ls = (ld_ls > 4'd9) ? 4'd9 : ld_ls;

  // One-second tick: the cycle on which the prescaler wraps, only while running.
  assign w_tick     = (r_state == RUN) && (r_pre == PRE_MAX);
  // The tick that takes 01 down to 00 ends the countdown.
  assign w_expiring = w_tick && (HS == 4'd0) && (LS == 4'd1);

  // Next-state, prescaler and digit update; load has priority over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_hs_nxt    = HS;
    w_ls_nxt    = LS;
    w_done_nxt  = 1'b0;
    if (load) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
      w_hs_nxt    = w_ld_hs;
      w_ls_nxt    = w_ld_ls;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A zero preset cannot be started; start+pause together is a no-op.
          if (start && !pause && ({HS, LS} != 8'h00))
            w_state_nxt = RUN;
        end
        RUN: begin
          w_pre_nxt = w_tick ? 26'd0 : (r_pre + 26'd1);
          if (w_tick) begin
            // BCD borrow: units wrap to 9 and tens decrement.
            if (LS != 4'd0) begin
              w_ls_nxt = LS - 4'd1;
            end else begin
              w_hs_nxt = HS - 4'd1;
              w_ls_nxt = 4'd9;
            end
          end
          // Expiry wins over a simultaneous pause; a pause still lets the tick land.
          if (w_expiring) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else if (pause) begin
            w_state_nxt = PAUSE;
          end
        end
        PAUSE: begin
          // The prescaler is held, so resuming finishes the partial second.
          if (start && !pause)
            w_state_nxt = RUN;
        end
        DONE: begin
          // Only load or reset leaves DONE; the display stays at 00.
          w_hs_nxt = 4'd0;
          w_ls_nxt = 4'd0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, prescaler and digit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pre   <= '0;
      HS      <= 4'd0;
      LS      <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      HS      <= w_hs_nxt;
      LS      <= w_ls_nxt;
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      running <= (w_state_nxt == RUN);
      expired <= (w_state_nxt == DONE);
      done    <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_count_down.sv
// tb_count_down: scoreboard bench for count_down with TICK_DIV=4.
// A seconds-based reference model pushes the expected outputs each clock;
// a monitor pops them one time unit after the edge and compares.
module tb_count_down;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ld_hs = 4'd0;
  logic [3:0] ld_ls = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] HS, LS;
  logic       running, expired, done;

  int n_chk = 0;
  int n_err = 0;

  count_down #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .load(load), .ld_hs(ld_hs), .ld_ls(ld_ls),
    .start(start), .pause(pause), .HS(HS), .LS(LS),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: remaining time kept as an integer number of seconds.
  int m_sec, m_st, m_pre;
  logic [10:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    int s, st, pr;
    logic dn;
    if (!rst) begin
      m_sec <= 0; m_st <= 0; m_pre <= 0;
    end else begin
      s = m_sec; st = m_st; pr = m_pre; dn = 1'b0;
      if (load) begin
        s  = ((ld_hs > 5) ? 5 : int'(ld_hs)) * 10 + ((ld_ls > 9) ? 9 : int'(ld_ls));
        pr = 0; st = 0;
      end else begin
        case (st)
          0: if (start && !pause && s != 0) st = 1;
          1: begin
            if (pr == TD - 1) begin
              pr = 0; s = s - 1;
              if (s == 0) begin st = 3; dn = 1'b1; end
            end else pr = pr + 1;
            if (st == 1 && pause) st = 2;
          end
          2: if (start && !pause) st = 1;
          default: ;
        endcase
      end
      m_sec <= s; m_st <= st; m_pre <= pr;
      exp_q.push_back({4'(s / 10), 4'(s % 10), st == 1, st == 3, dn});
    end
  end

  // Monitor: compare every clock against the model, or against zero in reset.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (!rst) begin
      chk("reset_outs", {HS, LS, running, expired, done}, 11'd0);
    end else if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("cycle", {HS, LS, running, expired, done}, e);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] l);
    load = 1'b1; ld_hs = h; ld_ls = l;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("por_zero", {HS, LS, running, expired, done}, 11'd0);
    rst = 1'b1;
    cyc(1);

    // Basic countdown 03 -> 00 at 4-cycle spacing.
    do_load(4'd0, 4'd3);
    chk("ld03", {HS, LS}, 8'h03);
    do_start;
    cyc(3);
    chk("pre_tick", {HS, LS, running}, {8'h03, 1'b1});
    cyc(1);
    chk("dec02", {HS, LS}, 8'h02);
    cyc(4);
    chk("dec01", {HS, LS}, 8'h01);
    cyc(4);
    chk("dec00", {HS, LS, running, expired, done}, {8'h00, 3'b011});
    cyc(1);
    chk("done_once", {expired, done}, 2'b10);
    // Start in DONE is ignored.
    do_start;
    cyc(2);
    chk("done_start", {HS, LS, running, expired}, {8'h00, 2'b01});

    // Borrow and clamp.
    do_load(4'd1, 4'd0);
    do_start;
    cyc(4);
    chk("borrow09", {HS, LS}, 8'h09);
    do_load(4'd6, 4'hF);
    chk("clamp59", {HS, LS, running, expired}, {8'h59, 2'b00});

    // Pause holds the partial second.
    do_load(4'd0, 4'd2);
    do_start;
    cyc(1);
    pause = 1'b1; cyc(1); pause = 1'b0;
    cyc(10);
    chk("pause_hold", {HS, LS, running}, {8'h02, 1'b0});
    do_start;
    cyc(1);
    chk("resume_1", {HS, LS, running}, {8'h02, 1'b1});
    cyc(1);
    chk("resume_2", {HS, LS}, 8'h01);

    // Edge requests in IDLE.
    do_load(4'd0, 4'd0);
    do_start;
    cyc(1);
    chk("start_00", {running, expired}, 2'b00);
    do_load(4'd0, 4'd4);
    start = 1'b1; pause = 1'b1; cyc(2); start = 1'b0; pause = 1'b0;
    chk("start_pause", {HS, LS, running}, {8'h04, 1'b0});

    // Load on a tick cycle overrides the decrement and clears the prescaler.
    do_load(4'd0, 4'd7);
    do_start;
    cyc(3);
    do_load(4'd0, 4'd5);
    chk("ld_override", {HS, LS, running}, {8'h05, 1'b0});
    cyc(3);
    chk("ld_idle", {HS, LS, running}, {8'h05, 1'b0});
    do_start;
    cyc(3);
    chk("pre_clr", {HS, LS}, 8'h05);
    cyc(1);
    chk("pre_clr_dec", {HS, LS}, 8'h04);

    // Asynchronous reset mid-run.
    do_load(4'd0, 4'd3);
    do_start;
    cyc(2);
    #2 rst = 1'b0;
    #1 chk("async_rst", {HS, LS, running, expired, done}, 11'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    do_start;
    cyc(6);
    chk("post_rst_idle", {HS, LS, running, expired, done}, 11'd0);

    cyc(1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/count_down.md
COUNT_DOWN -- requirements
Module: count_down

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000000, meaning clk cycles per one-second tick (legal range 2..2^26).
REQ-002 SHALL provide port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port load  input  1  level-sampled preset strobe.
REQ-005 SHALL provide port ld_hs  input  4  preset tens-of-seconds BCD digit.
REQ-006 SHALL provide port ld_ls  input  4  preset units-of-seconds BCD digit.
REQ-007 SHALL provide port start  input  1  begin/resume request.
REQ-008 SHALL provide port pause  input  1  suspend request.
REQ-009 SHALL provide port HS  output  4  current tens digit, BCD 0-5.
REQ-010 SHALL provide port LS  output  4  current units digit, BCD 0-9.
REQ-011 SHALL provide port running  output  1  high while in state RUN.
REQ-012 SHALL provide port expired  output  1  high while in state DONE.
REQ-013 SHALL provide port done  output  1  one-cycle pulse on expiry.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-015 SHALL hold a 26-bit prescaler that increments only in RUN, wraps to 0 at TICK_DIV-1 and asserts an internal tick on that wrap cycle.
REQ-016 SHALL hold the prescaler value unchanged in PAUSE, so resume continues the partial second.
REQ-017 SHALL, on load=1 in any state, take HS<=min(ld_hs,5), LS<=min(ld_ls,9), clear prescaler, go IDLE, next cycle; load overrides start, pause and tick in that cycle.
REQ-018 SHALL, in IDLE with start=1, pause=0 and HS:LS != 00, go RUN; start with HS:LS==00 SHALL be ignored (stay IDLE).
REQ-019 SHALL, in RUN with pause=1, go PAUSE; a tick in that same cycle SHALL still decrement.
REQ-020 SHALL, in PAUSE with start=1 and pause=0, return to RUN; start and pause both high SHALL leave the state unchanged in IDLE/PAUSE.
REQ-021 SHALL, on tick in RUN: if LS!=0 then LS<=LS-1; else HS<=HS-1 and LS<=9 (BCD borrow, never produce LS>9).
REQ-022 SHALL, on the tick that changes HS:LS from 01 to 00, go DONE and drive done=1 for exactly the first cycle HS:LS reads 00.
REQ-023 SHALL, in DONE, hold HS:LS=00, expired=1, prescaler frozen; start and pause SHALL be ignored; only load or reset leaves DONE.
REQ-024 SHALL keep running and expired mutually exclusive; done SHALL never be high outside the DONE entry cycle.

Reset
REQ-025 SHALL, on rst=0 asynchronously, force state IDLE, HS=0, LS=0, prescaler=0, running=0, expired=0, done=0.
REQ-026 SHALL, on reset asserted mid-RUN, abort the countdown with no done pulse; after release the block stays IDLE until a load.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification (TICK_DIV=4 for simulation)
REQ-028 SHALL test basic countdown: load 0:3, start -> HS:LS 03,02,01,00 at 4-cycle spacing, done single pulse on 00, expired=1 thereafter.
REQ-029 SHALL test borrow: load 1:0, start, one tick -> HS:LS=09; load 6:F -> clamps to 59.
REQ-030 SHALL test pause: load 0:2, start, pause after 2 cycles, hold 10 cycles, start -> next decrement occurs 2 cycles after resume, values unchanged during pause.
REQ-031 SHALL test edge requests: start with 00 loaded -> stays IDLE, running=0; start and pause together in IDLE -> stays IDLE; start in DONE -> ignored.
REQ-032 SHALL test load override: load 0:5 asserted in RUN on a tick cycle -> HS:LS=05, IDLE, prescaler=0, no decrement.
REQ-033 SHALL test async reset: drop rst between clk edges in RUN -> outputs zero immediately, no done pulse, IDLE after release.
